// File: rtl/branch_update_queue_if.sv
// Fetch/execute-side bundle for the branch update queue.
// The slave modport is the queue itself; the master modport is the pipeline
// driving enqueues and resolves and receiving predictor updates.
interface branch_update_queue_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Enq_valid;
    logic [AW-1:0] Enq_addr;
    logic          Enq_pred;
    logic          Enq_ready;
    logic          Resolve_valid;
    logic          Resolve_taken;
    logic [AW-1:0] Branch_addr_OUT;
    logic          Branch_resolved_OUT;
    logic          Update_valid;
    logic          Mispredict;
    logic          Underflow;
    logic [CW-1:0] Count;

    modport master (
        output Enq_valid, Enq_addr, Enq_pred, Resolve_valid, Resolve_taken,
        input  Enq_ready, Branch_addr_OUT, Branch_resolved_OUT,
               Update_valid, Mispredict, Underflow, Count
    );

    modport slave (
        input  Enq_valid, Enq_addr, Enq_pred, Resolve_valid, Resolve_taken,
        output Enq_ready, Branch_addr_OUT, Branch_resolved_OUT,
               Update_valid, Mispredict, Underflow, Count
    );
endinterface

// File: rtl/branch_update_queue.sv
// In-order queue of predicted conditional branches between fetch and execute.
// Each resolve pops the oldest entry and produces a registered predictor
// update one cycle later; a mispredict also squashes all younger entries.
module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FLUSH,
    branch_update_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DEPTH-1:0] pred_mem;

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW-1:0] rd_next, wr_next;
    logic [CW-1:0] count_q, count_next;

    logic full, empty;
    logic resolve_acc, enq_acc, mispredict_now, underflow_now;
    logic [AW-1:0] head_addr;
    logic          head_pred;

    // Full/empty come only from the registered count, so an enqueue is refused
    // while full even if a resolve frees a slot in the same cycle.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_addr = addr_mem[rd_ptr];
    assign head_pred = pred_mem[rd_ptr];

    assign resolve_acc    = bus.Resolve_valid && !empty && !FLUSH;
    assign mispredict_now = resolve_acc && (bus.Resolve_taken != head_pred);
    assign enq_acc        = bus.Enq_valid && !full && !FLUSH && !mispredict_now;
    assign underflow_now  = bus.Resolve_valid && empty && !FLUSH;

    assign bus.Enq_ready = !full;
    assign bus.Count     = count_q;

    // Next pointer/occupancy: flush empties, mispredict squashes wrong-path entries.
    always_comb begin
        rd_next    = rd_ptr;
        wr_next    = wr_ptr;
        count_next = count_q;
        if (FLUSH) begin
            rd_next    = '0;
            wr_next    = '0;
            count_next = '0;
        end else if (mispredict_now) begin
            rd_next    = rd_ptr + 1'b1;
            wr_next    = rd_ptr + 1'b1;
            count_next = '0;
        end else begin
            if (enq_acc) begin
                wr_next = wr_ptr + 1'b1;
            end
            if (resolve_acc) begin
                rd_next = rd_ptr + 1'b1;
            end
            if (enq_acc && !resolve_acc) begin
                count_next = count_q + 1'b1;
            end else if (!enq_acc && resolve_acc) begin
                count_next = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_next;
            wr_ptr  <= wr_next;
            count_q <= count_next;
        end
    end

    // Entry storage; contents of unoccupied slots never reach the outputs.
    always_ff @(posedge CLK) begin
        if (enq_acc) begin
            addr_mem[wr_ptr] <= bus.Enq_addr;
            pred_mem[wr_ptr] <= bus.Enq_pred;
        end
    end

    // Registered update pulses; address and outcome are zero when no update.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bus.Update_valid        <= 1'b0;
            bus.Branch_addr_OUT     <= '0;
            bus.Branch_resolved_OUT <= 1'b0;
            bus.Mispredict          <= 1'b0;
            bus.Underflow           <= 1'b0;
        end else begin
            bus.Update_valid        <= resolve_acc;
            bus.Branch_addr_OUT     <= resolve_acc ? head_addr : '0;
            bus.Branch_resolved_OUT <= resolve_acc && bus.Resolve_taken;
            bus.Mispredict          <= mispredict_now;
            bus.Underflow           <= underflow_now;
        end
    end
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: a vector table for single-cycle
// behaviour plus hand-written sequences for fill/drain, wrap and async reset.
module tb_branch_update_queue;
    logic CLK;
    logic RESET;
    logic FLUSH;

    int total;
    int bad;

    branch_update_queue_if #(.DEPTH(8), .AW(32)) bus ();

    branch_update_queue #(.DEPTH(8), .AW(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .FLUSH (FLUSH),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic        pred;
        logic        rv;
        logic        rt;
        logic        fl;
        logic        uv;
        logic [31:0] oaddr;
        logic        ores;
        logic        omis;
        logic        ound;
        logic [3:0]  cnt;
        logic        rdy;
    } vec_t;

    vec_t vecs [20];

    // Packed view: {Update_valid, addr, resolved, mispredict, underflow, count, ready}
    function automatic logic [40:0] exp_pack(input logic uv, input logic [31:0] a,
                                             input logic r, input logic m, input logic u,
                                             input logic [3:0] c, input logic rdy);
        return {uv, a, r, m, u, c, rdy};
    endfunction

    task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic pred,
                                 input logic rv, input logic rt, input logic fl);
        @(negedge CLK);
        bus.Enq_valid     = en;
        bus.Enq_addr      = addr;
        bus.Enq_pred      = pred;
        bus.Resolve_valid = rv;
        bus.Resolve_taken = rt;
        FLUSH             = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [40:0] expected);
        logic [40:0] actual;
        actual = {bus.Update_valid, bus.Branch_addr_OUT, bus.Branch_resolved_OUT,
                  bus.Mispredict, bus.Underflow, bus.Count, bus.Enq_ready};
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got uv/addr/res/mis/und/cnt/rdy=%h expected %h",
                     name, actual, expected);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        RESET = 1'b0;
        FLUSH = 1'b0;
        bus.Enq_valid     = 1'b0;
        bus.Enq_addr      = '0;
        bus.Enq_pred      = 1'b0;
        bus.Resolve_valid = 1'b0;
        bus.Resolve_taken = 1'b0;

        //        en    addr          pred  rv    rt    fl    uv    oaddr         res   mis   und   cnt   rdy
        vecs[0]  = '{1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[3]  = '{1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[4]  = '{1'b1, 32'h0000_0204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd2, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0208, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd3, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_0304, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_0504, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd2, 1'b1};
        vecs[14] = '{1'b1, 32'h0000_0508, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd3, 1'b1};
        vecs[15] = '{1'b1, 32'h0000_050C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[17] = '{1'b1, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[18] = '{1'b1, 32'h0000_0604, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[19] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0604, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};

        // Reset state while RESET is held low
        #2;
        checkOutput("reset_state", exp_pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
        @(negedge CLK);
        RESET = 1'b1;

        // Table-driven single-cycle behaviour
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].en, vecs[i].addr, vecs[i].pred,
                          vecs[i].rv, vecs[i].rt, vecs[i].fl);
            checkOutput($sformatf("vec%0d", i),
                        exp_pack(vecs[i].uv, vecs[i].oaddr, vecs[i].ores, vecs[i].omis,
                                 vecs[i].ound, vecs[i].cnt, vecs[i].rdy));
        end

        // Fill to eight, drop a ninth, then drain in order
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("fill%0d", i),
                        exp_pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'(i + 1), (i != 7)));
        end
        applyStimulus(1'b1, 32'h120, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("full_drop", exp_pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0));
        applyStimulus(1'b1, 32'h120, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("full_enq_res", exp_pack(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1));
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("drain%0d", i),
                        exp_pack(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 4'(7 - i), 1'b1));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("drain_underflow", exp_pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1));

        // Steady enqueue+resolve at depth two across pointer wrap
        applyStimulus(1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h704, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_prefill", exp_pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1));
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 32'h700 + 32'(4 * (k + 2)), 1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("wrap%0d", k),
                        exp_pack(1'b1, 32'h700 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 4'd2, 1'b1));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("wrap_tail0", exp_pack(1'b1, 32'h750, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("wrap_tail1", exp_pack(1'b1, 32'h754, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1));

        // Asynchronous reset mid-cycle with five entries and a live update pulse
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h800 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("pre_reset", exp_pack(1'b1, 32'h800, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1));
        bus.Resolve_valid = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        checkOutput("async_reset", exp_pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
        @(negedge CLK);
        RESET = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_empty", exp_pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1));
        applyStimulus(1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_enq", exp_pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_res", exp_pack(1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
